uart_tx_arbiter: RTL

Shares the single UART transmitter of the watch base between NUM_REQ byte-stream requesters, e.g. the RX echo FIFO and a status/message source. Grants one requester at a time by round-robin, holds the grant across a multi-byte packet until that requester's last byte, and feeds the TX core one byte per frame using its DV/Active/Done handshake. Sits between the requester FIFOs and the UART TX core, all in the system clock domain.

---
 rtl/uart_tx_arbiter_pkg.sv | 17 +
 rtl/uart_tx_arbiter_rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// watch_pkg: shared types and constants for the watch base UART path.
//   arb_state_t   : arbiter states (IDLE, SEND, WAIT, HOLD)
//   FPGA_clk_freq : default system clock frequency in Hz
//   baudrate      : default UART baud rate
package watch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } arb_state_t;

    localparam int FPGA_clk_freq = 32'sd50000000;
    localparam int baudrate      = 32'sd115200;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req_valid : per-requester valid bits
//   rr_ptr    : requester index with highest priority
//   winner    : first valid index at or after rr_ptr, wrapping
//   any_valid : at least one requester is valid
module rr_pick
    import watch_pkg::*;
#(
    parameter int NUM_REQ = 32'sd2,
    parameter int GW      = 32'sd1
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [GW-1:0]      rr_ptr,
    output logic [GW-1:0]      winner,
    output logic               any_valid
);

    logic [GW-1:0] pick_s;

    // Two descending passes: the lowest valid index below the pointer is the
    // fallback, the lowest valid index at/above the pointer overrides it.
    always_comb begin
        pick_s = '0;
        for (int i = NUM_REQ - 32'sd1; i >= 32'sd0; i--) begin
            pick_s = (req_valid[i] && (GW'(i) < rr_ptr)) ? GW'(i) : pick_s;
        end
        for (int i = NUM_REQ - 32'sd1; i >= 32'sd0; i--) begin
            pick_s = (req_valid[i] && (GW'(i) >= rr_ptr)) ? GW'(i) : pick_s;
        end
    end

    assign winner    = pick_s;
    assign any_valid = |req_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX core between NUM_REQ byte streams.
// Round-robin grant, held for a whole packet (until the byte flagged last).
//   clk, rst            : system clock, async active-high reset
//   req_valid/data/last : requester byte streams (data packed i*WIDTH)
//   req_ready           : one-hot accept strobe (combinational)
//   o_TX_DV, o_TX_Byte  : start strobe and byte to the TX core
//   i_TX_Active/Done    : TX core status and frame-finished pulse
//   o_grant             : index of current or last owner
//   o_busy              : a packet grant is held
//   o_timeout           : pulse when a stalled packet grant is dropped
module uart_tx_arbiter
    import watch_pkg::*;
#(
    parameter  int NUM_REQ      = 32'sd2,
    parameter  int WIDTH        = 32'sd8,
    parameter  int LOCK_TIMEOUT = 32'sd0,
    localparam int GW = (NUM_REQ > 32'sd1) ? $clog2(NUM_REQ) : 32'sd1,
    localparam int CW = (LOCK_TIMEOUT > 32'sd0) ? $clog2(LOCK_TIMEOUT + 32'sd1) : 32'sd1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     o_TX_DV,
    output logic [WIDTH-1:0]         o_TX_Byte,
    input  logic                     i_TX_Active,
    input  logic                     i_TX_Done,
    output logic [GW-1:0]            o_grant,
    output logic                     o_busy,
    output logic                     o_timeout
);

    arb_state_t       state_r;
    logic [GW-1:0]    rr_ptr_r;
    logic [GW-1:0]    grant_r;
    logic [WIDTH-1:0] byte_r;
    logic             last_r;
    logic             dv_r;
    logic             busy_r;
    logic             timeout_r;
    logic [CW-1:0]    lock_cnt_r;

    logic [GW-1:0]      win_s;
    logic               any_valid_s;
    logic [GW-1:0]      sel_idx_s;
    logic [WIDTH-1:0]   sel_data_s;
    logic               sel_last_s;
    logic               sel_valid_s;
    logic               xfer_s;
    logic [NUM_REQ-1:0] ready_s;
    logic [GW-1:0]      next_ptr_s;
    logic               lock_hit_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_r),
        .winner    (win_s),
        .any_valid (any_valid_s)
    );

    // Source select: the round-robin winner in IDLE, the packet owner otherwise.
    always_comb begin
        sel_idx_s   = (state_r == HOLD) ? grant_r : win_s;
        sel_data_s  = '0;
        sel_last_s  = 1'b0;
        sel_valid_s = 1'b0;
        for (int i = 32'sd0; i < NUM_REQ; i++) begin
            sel_data_s  = (GW'(i) == sel_idx_s) ? req_data[i*WIDTH +: WIDTH] : sel_data_s;
            sel_last_s  = (GW'(i) == sel_idx_s) ? req_last[i]  : sel_last_s;
            sel_valid_s = (GW'(i) == sel_idx_s) ? req_valid[i] : sel_valid_s;
        end
    end

    // Accept decision; gated by rst so req_ready is low while reset is held.
    always_comb begin
        xfer_s = 1'b0;
        case (state_r)
            IDLE:    xfer_s = any_valid_s && !i_TX_Active && !rst;
            HOLD:    xfer_s = sel_valid_s && !rst;
            default: xfer_s = 1'b0;
        endcase
        for (int i = 32'sd0; i < NUM_REQ; i++) begin
            ready_s[i] = xfer_s && (GW'(i) == sel_idx_s);
        end
    end

    assign next_ptr_s = (grant_r == GW'(NUM_REQ - 32'sd1)) ? '0 : grant_r + GW'(1);
    assign lock_hit_s = (LOCK_TIMEOUT > 32'sd0) &&
                        (lock_cnt_r == CW'(LOCK_TIMEOUT - 32'sd1));

    // Arbiter FSM with registered TX strobe, byte, grant, busy and timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            rr_ptr_r   <= '0;
            grant_r    <= '0;
            byte_r     <= '0;
            last_r     <= 1'b0;
            dv_r       <= 1'b0;
            busy_r     <= 1'b0;
            timeout_r  <= 1'b0;
            lock_cnt_r <= '0;
        end else begin
            dv_r      <= 1'b0;
            timeout_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (xfer_s) begin
                        byte_r  <= sel_data_s;
                        last_r  <= sel_last_s;
                        grant_r <= sel_idx_s;
                        dv_r    <= 1'b1;
                        busy_r  <= 1'b1;
                        state_r <= SEND;
                    end
                end
                SEND: begin
                    // A Done coinciding with the start strobe belongs to an
                    // earlier frame and is ignored here.
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (i_TX_Done) begin
                        if (last_r) begin
                            rr_ptr_r <= next_ptr_s;
                            busy_r   <= 1'b0;
                            state_r  <= IDLE;
                        end else begin
                            lock_cnt_r <= '0;
                            state_r    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (xfer_s) begin
                        byte_r  <= sel_data_s;
                        last_r  <= sel_last_s;
                        dv_r    <= 1'b1;
                        state_r <= SEND;
                    end else if (lock_hit_s) begin
                        timeout_r <= 1'b1;
                        rr_ptr_r  <= next_ptr_s;
                        busy_r    <= 1'b0;
                        state_r   <= IDLE;
                    end else if (LOCK_TIMEOUT > 32'sd0) begin
                        lock_cnt_r <= lock_cnt_r + CW'(1);
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = ready_s;
    assign o_TX_DV   = dv_r;
    assign o_TX_Byte = byte_r;
    assign o_grant   = grant_r;
    assign o_busy    = busy_r;
    assign o_timeout = timeout_r;

endmodule
